// File: rtl/i2c_pkg.sv
// Shared I2C clock-generator definitions: mode/phase encodings, bus rates,
// divider computation and phase output decode.
package i2c_pkg;

  localparam int unsigned RATE_STD   = 100_000;
  localparam int unsigned RATE_FAST  = 400_000;
  localparam int unsigned RATE_FASTP = 1_000_000;

  typedef enum logic [1:0] {
    MODE_STD   = 2'd0,
    MODE_FAST  = 2'd1,
    MODE_FASTP = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P0   = 3'd1,
    PH_P1   = 3'd2,
    PH_P2   = 3'd3,
    PH_P3   = 3'd4
  } phase_e;

  function automatic int unsigned bus_rate(mode_e m);
    case (m)
      MODE_FAST:  return RATE_FAST;
      MODE_FASTP: return RATE_FASTP;
      default:    return RATE_STD;
    endcase
  endfunction

  // Quarter-period terminal count: each phase lasts div+1 system cycles.
  function automatic int unsigned div_for(int unsigned clk_hz, mode_e m);
    return clk_hz / (4 * bus_rate(m)) - 1;
  endfunction

  function automatic phase_e next_phase(phase_e p);
    case (p)
      PH_P0:   return PH_P1;
      PH_P1:   return PH_P2;
      PH_P2:   return PH_P3;
      default: return PH_P0;
    endcase
  endfunction

  // Returns {sclk, dclk} for a phase.
  function automatic logic [1:0] phase_lvl(phase_e p);
    case (p)
      PH_P0:   return 2'b10;
      PH_P1:   return 2'b00;
      PH_P2:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchronizer for the sensed SCL level; resets to the released (1) level.
module i2c_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_clk_gen.sv
// I2C SCL/data-phase generator with Standard/Fast/Fast-plus rates.
// Slave clock stretching is built only when I2C_CLK_STRETCH_EN is defined.
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       scl_in,
  output logic       sclk,
  output logic       dclk,
  output logic       q_stb,
  output logic       rise_stb,
  output logic       fall_stb,
  output logic       stretch
);

  localparam logic [CNT_W-1:0] DIV_STD   = CNT_W'(div_for(CLK_HZ, MODE_STD));
  localparam logic [CNT_W-1:0] DIV_FAST  = CNT_W'(div_for(CLK_HZ, MODE_FAST));
  localparam logic [CNT_W-1:0] DIV_FASTP = CNT_W'(div_for(CLK_HZ, MODE_FASTP));

  phase_e           phase;
  mode_e            mode_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             hold;

  always_comb begin
    div = DIV_STD;
    case (mode_q)
      MODE_FAST:  div = DIV_FAST;
      MODE_FASTP: div = DIV_FASTP;
      default:    div = DIV_STD;
    endcase
  end

`ifdef I2C_CLK_STRETCH_EN
  logic scl_s;

  i2c_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (scl_in),
    .q     (scl_s)
  );

  // Ignore the first two P3 counts: the synchronizer still shows our own low drive.
  assign hold = (phase == PH_P3) && (cnt >= CNT_W'(2)) && !scl_s;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_IDLE;
      mode_q   <= MODE_STD;
      cnt      <= '0;
      sclk     <= 1'b1;
      dclk     <= 1'b1;
      q_stb    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      stretch  <= 1'b0;
    end else begin
      q_stb    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      if (!en) begin
        phase   <= PH_IDLE;
        cnt     <= '0;
        stretch <= 1'b0;
        sclk    <= 1'b1;
        dclk    <= 1'b1;
      end else if (phase == PH_IDLE) begin
        phase   <= PH_P0;
        cnt     <= '0;
        mode_q  <= mode_e'(mode);
        stretch <= 1'b0;
        {sclk, dclk} <= phase_lvl(PH_P0);
      end else if (hold) begin
        stretch <= 1'b1;
      end else begin
        stretch <= 1'b0;
        if (cnt == div) begin
          // Tick uses the old divider; the new mode is latched only at the period boundary.
          cnt          <= '0;
          q_stb        <= 1'b1;
          phase        <= next_phase(phase);
          {sclk, dclk} <= phase_lvl(next_phase(phase));
          if (phase == PH_P0) fall_stb <= 1'b1;
          if (phase == PH_P2) rise_stb <= 1'b1;
          if (phase == PH_P3) mode_q   <= mode_e'(mode);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_clk_gen.sv
// Directed bench for i2c_clk_gen at 100 MHz: reset, per-mode timing table,
// mode change, enable drop and (when I2C_CLK_STRETCH_EN is defined) stretching.
module tb_i2c_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       scl_in = 1'b1;
  logic       sclk, dclk, q_stb, rise_stb, fall_stb, stretch;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_clk_gen #(.CLK_HZ(100_000_000), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .scl_in   (scl_in),
    .sclk     (sclk),
    .dclk     (dclk),
    .q_stb    (q_stb),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .stretch  (stretch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         per;
    int         high;
    int         ddly;
    int         qgap;
  } vec_t;

  vec_t vecs[4];

  localparam int LIMIT = 5000;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit hit(input int which);
    case (which)
      0:       return fall_stb;
      1:       return rise_stb;
      default: return q_stb && sclk && !dclk;
    endcase
  endfunction

  // which: 0 = fall_stb, 1 = rise_stb, 2 = P3->P0 tick
  task automatic count_until(input int which, output int n, output bit to);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hit(which) && n < LIMIT);
    to = !hit(which);
  endtask

  task automatic restart(input logic [1:0] m);
    en = 1'b0;
    repeat (2) @(negedge clk);
    mode = m;
    en   = 1'b1;
  endtask

  task automatic measure(output int per, output int high, output int ddly,
                         output int nrise, output int nq, output int qgap,
                         output bit to);
    int n;
    count_until(0, n, to);
    per = 0; high = 0; ddly = -1; nrise = 0; nq = 0; qgap = -1;
    if (to) return;
    do begin
      @(negedge clk);
      per++;
      if (sclk) high++;
      if (dclk && ddly < 0) ddly = per;
      if (rise_stb) nrise++;
      if (q_stb) begin
        nq++;
        if (qgap < 0) qgap = per;
      end
    end while (!fall_stb && per < LIMIT);
    to = !fall_stb;
  endtask

  initial begin
    int  per, high, ddly, nrise, nq, qgap, n, n1, n2, n3, bad, st_cnt, st_first, p3_len;
    bit  to;

    vecs[0] = '{mode: 2'd0, per: 1000, high: 500, ddly: 250, qgap: 250};
    vecs[1] = '{mode: 2'd1, per: 248,  high: 124, ddly: 62,  qgap: 62};
    vecs[2] = '{mode: 2'd2, per: 100,  high: 50,  ddly: 25,  qgap: 25};
    vecs[3] = '{mode: 2'd3, per: 1000, high: 500, ddly: 250, qgap: 250};

    // Power-on reset
    #3 rst_n = 1'b0;
    #1 check("reset_outputs", {sclk, dclk, q_stb, rise_stb, fall_stb, stretch}, 6'b110000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {sclk, dclk, q_stb, rise_stb, fall_stb, stretch}, 6'b110000);

    // Per-mode timing table
    for (int i = 0; i < 4; i++) begin
      restart(vecs[i].mode);
      measure(per, high, ddly, nrise, nq, qgap, to);
      check($sformatf("m%0d_timeout", i), to, 0);
      check($sformatf("m%0d_period", i), per, vecs[i].per);
      check($sformatf("m%0d_high", i), high, vecs[i].high);
      check($sformatf("m%0d_dclk_delay", i), ddly, vecs[i].ddly);
      check($sformatf("m%0d_qgap", i), qgap, vecs[i].qgap);
      check($sformatf("m%0d_rise_cnt", i), nrise, 1);
      check($sformatf("m%0d_q_cnt", i), nq, 4);
    end

    // Asynchronous reset in the middle of P1, then idle with en low
    restart(2'd0);
    count_until(0, n, to);
    check("rst_sync_timeout", to, 0);
    repeat (100) @(negedge clk);
    check("rst_mid_p1_level", {sclk, dclk}, 2'b00);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_p1", {sclk, dclk, q_stb, rise_stb, fall_stb, stretch}, 6'b110000);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({sclk, dclk, q_stb, rise_stb, fall_stb, stretch} !== 6'b110000) bad++;
    end
    check("idle_hold", bad, 0);

    // Mode change 0 -> 2 mid-P1: current period stays 1000, next is 100
    restart(2'd0);
    count_until(2, n, to);
    check("mc_sync_timeout", to, 0);
    count_until(0, n1, to);
    repeat (100) @(negedge clk);
    mode = 2'd2;
    count_until(2, n2, to);
    check("mc_cur_period", n1 + 100 + n2, 1000);
    count_until(2, n3, to);
    check("mc_next_period", n3, 100);

    // en dropped in P2, reasserted 5 cycles later
    restart(2'd0);
    count_until(0, n, to);
    repeat (260) @(negedge clk);
    check("en_drop_in_p2", {sclk, dclk}, 2'b01);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_idle", {sclk, dclk, q_stb, rise_stb, fall_stb, stretch}, 6'b110000);
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_restart_p0", {sclk, dclk, q_stb}, 3'b100);
    count_until(0, n, to);
    check("en_restart_fall", n, 250);

    // Slave holds SCL low for 300 cycles starting 10 cycles into P3
    restart(2'd0);
    count_until(1, n, to);
    check("st_sync_timeout", to, 0);
    st_cnt = 0; st_first = -1; p3_len = -1;
    for (int i = 1; i < LIMIT; i++) begin
      @(negedge clk);
      if (stretch) begin
        st_cnt++;
        if (st_first < 0) st_first = i;
      end
      if (hit(2)) begin
        p3_len = i;
        break;
      end
      if (sclk !== 1'b1) bad++;
      if (i == 10)  scl_in = 1'b0;
      if (i == 310) scl_in = 1'b1;
    end
    scl_in = 1'b1;
    check("st_p0_levels", {sclk, dclk}, 2'b10);
`ifdef I2C_CLK_STRETCH_EN
    check("st_p3_len", p3_len, 550);
    check("st_cycles", st_cnt, 300);
    check("st_first", st_first, 13);
`else
    check("st_p3_len", p3_len, 250);
    check("st_cycles", st_cnt, 0);
    check("st_first", st_first, -1);
`endif
    check("st_sclk_held_high", bad, 0);
    count_until(0, n, to);
    check("st_next_fall", n, 250);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_clk_gen.md
Name: i2c_clk_gen

Overview:
Parametrised I2C bus-clock phase generator. It replaces the fixed 100 kHz divider with run-time selectable Standard (100 kHz), Fast (400 kHz) and Fast-plus (1 MHz) modes, derived from a configurable system clock frequency. It drives the SCL level (sclk), the SDA change/sample phase level (dclk) and single-cycle edge strobes, and honours slave clock stretching. It sits between the system clock and the i2c_master bit engine.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; must be >= 8 MHz.
- CNT_W, 16, width of the quarter-period counter; must hold the largest divider value.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low forces idle.
- mode  in  2  0 = Standard, 1 = Fast, 2 = Fast-plus, 3 = reserved (treated as Standard).
- scl_in  in  1  sensed SCL bus level, asynchronous; used for stretch detection.
- sclk  out  1  registered SCL drive level (1 = release).
- dclk  out  1  registered data phase level: 0 = SDA may change, 1 = SDA stable/sample.
- q_stb  out  1  one-cycle pulse on every phase advance.
- rise_stb  out  1  one-cycle pulse on the cycle sclk goes 0->1.
- fall_stb  out  1  one-cycle pulse on the cycle sclk goes 1->0.
- stretch  out  1  high while a phase advance is held off by a slave holding SCL low.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: sclk=1, dclk=1, q_stb=rise_stb=fall_stb=0, stretch=0, phase=IDLE, counter=0, latched mode=0.
- Divider values, with integer division: DIV_STD=CLK_HZ/400_000-1, DIV_FAST=CLK_HZ/1_600_000-1, DIV_FASTP=CLK_HZ/4_000_000-1. At 100 MHz these are 249, 61 and 24.
- State/phase machine: IDLE, P0, P1, P2, P3, with outputs:
  - IDLE: sclk=1, dclk=1.
  - P0: sclk=1, dclk=0.
  - P1: sclk=0, dclk=0.
  - P2: sclk=0, dclk=1.
  - P3: sclk=1, dclk=1.
  - Outputs are registered and take the new phase's values on the same edge the phase register changes.
- Leaving IDLE: on the first edge with en=1, go to P0, clear the counter, latch mode.
- Phase advance: the counter increments each cycle. When counter==DIV(latched mode) a tick occurs: counter<=0, phase advances P0->P1->P2->P3->P0, q_stb=1 for that cycle. Each phase lasts DIV+1 cycles, so the SCL period is 4*(DIV+1) cycles.
- Strobes: fall_stb pulses with the P0->P1 transition; rise_stb pulses with the P2->P3 transition.
- Mode changes: mode is re-latched only on the P3->P0 tick or when leaving IDLE. A change mid-period takes effect at the next period boundary.
- en deassert: immediate on the next edge, from any phase. Phase<=IDLE, counter<=0, all strobes 0, stretch<=0. Reasserting en restarts at P0.
- Stretching: scl_in passes through a 2-flop synchronizer.
  - In P3, once the counter is >= 2 (covering the synchronizer latency), a synchronized scl_in==0 freezes the counter and sets stretch=1.
  - When synchronized scl_in returns to 1, counting resumes from the frozen value and stretch clears on the same edge.
  - P3 is lengthened; no other phase is affected. There is no timeout.
- Simultaneous events: en=0 overrides a tick and a stretch. A tick and a mode change resolve as a tick using the old divider, then the latch takes the new mode.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: synchronizer and stretch logic are present, as described in Behaviour.
- Undefined: scl_in is ignored, the synchronizer is omitted, stretch is tied to 0, and P3 always lasts exactly DIV+1 cycles.

Decomposition:
- Shared package i2c_pkg holds:
  - mode encodings MODE_STD, MODE_FAST, MODE_FASTP;
  - phase encoding PH_IDLE, PH_P0..PH_P3;
  - bus rate constants 100_000, 400_000, 1_000_000;
  - a constant function computing the divider from CLK_HZ and mode.
- One sub-module, i2c_sync: 2-flop synchronizer with reset value 1, instantiated only under I2C_CLK_STRETCH_EN.

Test Plan:
- Reset and idle: assert rst_n low mid-P1, then hold en=0 -> sclk=1, dclk=1 and all strobes 0 immediately and throughout.
- Standard timing: CLK_HZ=100e6, mode=0, en=1 -> sclk period exactly 1000 cycles, high/low 500/500, dclk rises 250 cycles after each fall_stb, q_stb every 250 cycles.
- Fast and Fast-plus: mode=1 -> period 248 cycles; mode=2 -> period 100 cycles; exactly one rise_stb and one fall_stb per period.
- Mode change mid-P1 from 0 to 2 -> the current period completes at 1000 cycles, the next period is 100 cycles.
- Stretch (macro defined): hold scl_in low 300 cycles starting 10 cycles into P3 -> stretch high for that span plus synchronizer delay; P3 lengthened by the same amount; P0 follows without a glitch. Macro undefined -> P3 is unchanged at 250 cycles.
- en dropped in P2 and reasserted 5 cycles later -> IDLE (1/1) on the next edge, restart at P0, first fall_stb 250 cycles after restart.
